// File: rtl/mem_responder.sv
// Single-port 16-bit word memory slave with a programmable number of wait states per access.
// It accepts one request at a time and holds the response until the core consumes it.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// A response is consumed on a rising edge where rsp_valid && rsp_ready.
// Each side holds its payload stable until that edge.
module mem_responder #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  input  logic [2:0]  wait_cfg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     cnt;
  logic [15:0]    lat_addr;
  logic [15:0]    lat_wdata;
  logic           lat_we;
  logic [15:0]    mem [0:(1<<AW)-1];

  logic [15:0]    cur_addr;
  logic [15:0]    cur_wdata;
  logic           cur_we;
  logic           cur_err;
  logic [AW-1:0]  cur_idx;
  logic           accept;
  logic           enter_resp;

  // With zero wait states the accept edge is also the RESP-entry edge.
  // The live request fields therefore feed the datapath while in IDLE.
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_idx   = cur_addr[AW:1];
  assign cur_err   = cur_addr[0] | (|(cur_addr >> (AW + 1)));

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (state_nx == RESP) && (state != RESP);

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (wait_cfg == 3'd0) ? RESP : BUSY;
      BUSY:    if (cnt == 3'd1) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lat_addr  <= 16'd0;
      lat_wdata <= 16'd0;
      lat_we    <= 1'b0;
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt       <= wait_cfg;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_we    <= req_we;
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
      end
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_we || cur_err) ? 16'd0 : mem[cur_idx];
      end
    end
  end

  // Storage is not reset. The rst gate keeps a write that is in flight
  // during reset from ever being committed.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we && !cur_err)
      mem[cur_idx] <= cur_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks for mem_responder (AW=8).
// Expected responses and latencies come from a bench-side memory model and are queued at issue time.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic [2:0]  wait_cfg;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int passes = 0;
  int checks = 0;

  logic [16:0] exp_q[$];
  logic [31:0] lat_q[$];
  logic [15:0] mdl [0:255];

  mem_responder #(.AW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .wait_cfg(wait_cfg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one request.
  // Latency is counted in negedge samples from the accept edge until rsp_valid is seen.
  // bp > 0 holds rsp_ready low for bp cycles in RESP and pulses req_valid during that window.
  // bump changes wait_cfg right after accept.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [2:0] wc, input int bp, input logic bump);
    logic        err;
    logic [15:0] rd;
    logic [16:0] e;
    logic        rdy_bad;
    logic        unstable;
    logic [16:0] held;
    int          n;
    err = addr[0] || (addr[15:9] != 7'd0);
    rd  = (we || err) ? 16'd0 : mdl[addr[8:1]];
    if (we && !err) mdl[addr[8:1]] = wdata;
    exp_q.push_back({err, rd});
    lat_q.push_back(32'(wc) + 32'd1);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; wait_cfg = wc;
    rsp_ready = (bp == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom_range(0, 65535));
    req_wdata = 16'($urandom_range(0, 65535));
    wait_cfg  = bump ? 3'd7 : 3'($urandom_range(0, 7));
    n = 1;
    rdy_bad = 1'b0;
    while (!rsp_valid && n < 20) begin
      if (req_ready) rdy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (req_ready) rdy_bad = 1'b1;
    chk("latency", n, lat_q.pop_front());
    chk("ready_low_in_flight", {31'd0, rdy_bad}, 32'd0);
    e = exp_q.pop_front();
    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e[15:0]});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[16]});

    if (bp > 0) begin
      held = {rsp_err, rsp_rdata};
      unstable = 1'b0;
      for (int i = 0; i < bp; i++) begin
        req_valid = (i == 1);
        if (!rsp_valid || ({rsp_err, rsp_rdata} !== held)) unstable = 1'b1;
        @(negedge clk);
      end
      if (!rsp_valid || ({rsp_err, rsp_rdata} !== held)) unstable = 1'b1;
      chk("bp_stable", {31'd0, unstable}, 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_done_ready", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'd0;
    req_wdata = 16'd0; wait_cfg = 3'd0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Write then read with no wait states.
    issue(1'b1, 16'h0010, 16'hBEEF, 3'd0, 0, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 3'd0, 0, 1'b0);
    // Five wait states.
    issue(1'b0, 16'h0010, 16'h0000, 3'd5, 0, 1'b0);
    // Backpressure in RESP with an ignored req_valid pulse.
    issue(1'b0, 16'h0010, 16'h0000, 3'd2, 4, 1'b0);
    // Misaligned and out-of-range writes must not touch memory.
    issue(1'b1, 16'h0011, 16'h1234, 3'd0, 0, 1'b0);
    issue(1'b1, 16'h0200, 16'h1234, 3'd1, 0, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 3'd0, 0, 1'b0);
    issue(1'b0, 16'h8010, 16'h0000, 3'd3, 0, 1'b0);

    // A reset during BUSY drops the pending write.
    issue(1'b1, 16'h0020, 16'h1111, 3'd0, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555; wait_cfg = 3'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midbusy_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midbusy_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 16'h0020, 16'h0000, 3'd2, 0, 1'b0);

    // Last word, maximum latency, and a wait_cfg change during BUSY.
    issue(1'b1, 16'h01FE, 16'hABCD, 3'd0, 0, 1'b0);
    issue(1'b0, 16'h01FE, 16'h0000, 3'd7, 0, 1'b0);
    issue(1'b0, 16'h01FE, 16'h0000, 3'd3, 0, 1'b1);
    issue(1'b0, 16'h0010, 16'h0000, 3'd1, 0, 1'b1);

    // Randomized traffic over a pre-initialized window of words.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 16'h0040 + 16'(2 * i), 16'($urandom_range(0, 65535)),
            3'($urandom_range(0, 7)), 0, 1'b0);
    for (int i = 0; i < 16; i++)
      issue(1'($urandom_range(0, 1)), 16'h0040 + 16'(2 * $urandom_range(0, 7)),
            16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
